// File: rtl/cam_ddr_frame_writer.sv
// Camera-to-DDR frame writer: packs FIFO pixel bytes into AXI beats and writes
// fixed-length INCR bursts into a ring of frame buffers, skipping the reader's locked buffer.
module cam_ddr_frame_writer #(
  parameter int unsigned DATA_BITS    = 64,
  parameter int unsigned PIX_BITS     = 8,
  parameter int unsigned BURST_BEATS  = 16,
  parameter int unsigned NUM_FRAMES   = 3,
  parameter int unsigned FRAME_BYTES  = 307200,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0008_0000,
  parameter int unsigned CNT_BITS     = 12
) (
  input  logic                          aclk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          cmos_init_done,
  input  logic                          frame_sync,
  input  logic                          rd_lock,
  input  logic [$clog2(NUM_FRAMES)-1:0] rd_frame_index,
  input  logic [CNT_BITS-1:0]           fifo_data_count,
  input  logic [PIX_BITS-1:0]           fifo_data,
  output logic                          fifo_rd_en,
  output logic [31:0]                   awaddr_1,
  output logic [7:0]                    awlen_1,
  output logic                          awvalid_1,
  input  logic                          awready_1,
  output logic [DATA_BITS-1:0]          wdata_1,
  output logic                          wlast_1,
  output logic                          wvalid_1,
  input  logic                          wready_1,
  input  logic                          bvalid_1,
  output logic                          bready_1,
  output logic [$clog2(NUM_FRAMES)-1:0] wr_frame_index,
  output logic [$clog2(NUM_FRAMES)-1:0] last_done_index,
  output logic                          done_valid,
  output logic                          frame_done,
  output logic                          sync_err,
  output logic                          busy
);

  localparam int unsigned IW          = $clog2(NUM_FRAMES);
  localparam int unsigned BPB         = DATA_BITS / PIX_BITS;
  localparam int unsigned BURST_BYTES = BURST_BEATS * BPB;
  localparam int unsigned BCW         = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int unsigned BTW         = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  if ((DATA_BITS % PIX_BITS) != 0) begin : g_bad_data_bits
    $error("DATA_BITS must be a multiple of PIX_BITS");
  end
  if ((FRAME_BYTES % BURST_BYTES) != 0) begin : g_bad_frame_bytes
    $error("FRAME_BYTES must be a multiple of BURST_BYTES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SYNC, S_WAIT_DATA, S_AW, S_RD_BEAT, S_W, S_B
  } state_t;

  state_t               state, state_d;
  logic [31:0]          offset, offset_d;
  logic [BTW-1:0]       beat_cnt, beat_cnt_d;
  logic [BCW-1:0]       pop_cnt, pop_cnt_d;
  logic [BCW-1:0]       byte_cnt, byte_cnt_d;
  logic                 cap_en;
  logic                 sync_pend, sync_pend_d;
  logic                 fifo_rd_en_d, awvalid_d, wlast_d, wvalid_d, bready_d;
  logic [31:0]          awaddr_d;
  logic [DATA_BITS-1:0] wdata_d;
  logic [IW-1:0]        wr_idx_d, last_done_d;
  logic                 done_valid_d, frame_done_d, sync_err_d, busy_d;

  logic [IW-1:0]        nxt1, nxt2, adv_idx;
  logic [31:0]          offset_inc, frame_addr;

  assign awlen_1 = 8'(BURST_BEATS - 1);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    offset_d     = offset;
    beat_cnt_d   = beat_cnt;
    pop_cnt_d    = pop_cnt;
    byte_cnt_d   = byte_cnt;
    sync_pend_d  = sync_pend;
    fifo_rd_en_d = 1'b0;
    awvalid_d    = awvalid_1;
    awaddr_d     = awaddr_1;
    wdata_d      = wdata_1;
    wlast_d      = wlast_1;
    wvalid_d     = wvalid_1;
    bready_d     = bready_1;
    wr_idx_d     = wr_frame_index;
    last_done_d  = last_done_index;
    done_valid_d = done_valid;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err;

    nxt1       = (wr_frame_index == IW'(NUM_FRAMES - 1)) ? '0 : wr_frame_index + IW'(1);
    nxt2       = (nxt1 == IW'(NUM_FRAMES - 1)) ? '0 : nxt1 + IW'(1);
    adv_idx    = (rd_lock && (nxt1 == rd_frame_index)) ? nxt2 : nxt1;
    offset_inc = offset + 32'(BURST_BYTES);
    frame_addr = BASE_ADDR + 32'(wr_frame_index) * FRAME_STRIDE + offset;

    // A sync mid-burst is remembered; the burst itself is never aborted
    if (frame_sync && (state == S_AW || state == S_RD_BEAT || state == S_W)) begin
      sync_err_d  = 1'b1;
      sync_pend_d = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (enable && cmos_init_done) state_d = S_WAIT_SYNC;
      end
      S_WAIT_SYNC: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (frame_sync) begin
          state_d  = S_WAIT_DATA;
          offset_d = '0;
        end
      end
      S_WAIT_DATA: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (frame_sync) begin
          sync_err_d = 1'b1;
          offset_d   = '0;
        end else if (32'(fifo_data_count) >= 32'(BURST_BYTES)) begin
          state_d    = S_AW;
          awvalid_d  = 1'b1;
          awaddr_d   = frame_addr;
          beat_cnt_d = '0;
        end
      end
      S_AW: begin
        if (awready_1) begin
          state_d      = S_RD_BEAT;
          awvalid_d    = 1'b0;
          fifo_rd_en_d = 1'b1;
          pop_cnt_d    = '0;
          byte_cnt_d   = '0;
        end
      end
      S_RD_BEAT: begin
        if (fifo_rd_en) begin
          pop_cnt_d    = pop_cnt + BCW'(1);
          fifo_rd_en_d = (pop_cnt != BCW'(BPB - 1));
        end
        // Popped byte appears on fifo_data one cycle after the pop
        if (cap_en) begin
          wdata_d[32'(byte_cnt) * PIX_BITS +: PIX_BITS] = fifo_data;
          byte_cnt_d = byte_cnt + BCW'(1);
          if (byte_cnt == BCW'(BPB - 1)) begin
            state_d  = S_W;
            wvalid_d = 1'b1;
            wlast_d  = (beat_cnt == BTW'(BURST_BEATS - 1));
          end
        end
      end
      S_W: begin
        if (wready_1) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          if (wlast_1) begin
            state_d  = S_B;
            bready_d = 1'b1;
          end else begin
            state_d      = S_RD_BEAT;
            beat_cnt_d   = beat_cnt + BTW'(1);
            fifo_rd_en_d = 1'b1;
            pop_cnt_d    = '0;
            byte_cnt_d   = '0;
          end
        end
      end
      S_B: begin
        if (bvalid_1) begin
          bready_d = 1'b0;
          if (sync_pend || (frame_sync && (offset_inc != 32'(FRAME_BYTES)))) begin
            // Truncated frame: restart the same buffer from offset 0
            sync_err_d  = 1'b1;
            sync_pend_d = 1'b0;
            offset_d    = '0;
            state_d     = S_WAIT_DATA;
          end else if (offset_inc == 32'(FRAME_BYTES)) begin
            frame_done_d = 1'b1;
            last_done_d  = wr_frame_index;
            done_valid_d = 1'b1;
            wr_idx_d     = adv_idx;
            offset_d     = '0;
            state_d      = frame_sync ? S_WAIT_DATA : S_WAIT_SYNC;
          end else begin
            offset_d = offset_inc;
            state_d  = S_WAIT_DATA;
          end
          if (!enable) state_d = S_IDLE;
        end else if (frame_sync) begin
          sync_err_d  = 1'b1;
          sync_pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !(state_d == S_IDLE || state_d == S_WAIT_SYNC);
  end

  // State and output registers
  always_ff @(posedge aclk) begin
    if (rst) begin
      state           <= S_IDLE;
      offset          <= '0;
      beat_cnt        <= '0;
      pop_cnt         <= '0;
      byte_cnt        <= '0;
      cap_en          <= 1'b0;
      sync_pend       <= 1'b0;
      fifo_rd_en      <= 1'b0;
      awaddr_1        <= '0;
      awvalid_1       <= 1'b0;
      wdata_1         <= '0;
      wlast_1         <= 1'b0;
      wvalid_1        <= 1'b0;
      bready_1        <= 1'b0;
      wr_frame_index  <= '0;
      last_done_index <= '0;
      done_valid      <= 1'b0;
      frame_done      <= 1'b0;
      sync_err        <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_d;
      offset          <= offset_d;
      beat_cnt        <= beat_cnt_d;
      pop_cnt         <= pop_cnt_d;
      byte_cnt        <= byte_cnt_d;
      cap_en          <= fifo_rd_en;
      sync_pend       <= sync_pend_d;
      fifo_rd_en      <= fifo_rd_en_d;
      awaddr_1        <= awaddr_d;
      awvalid_1       <= awvalid_d;
      wdata_1         <= wdata_d;
      wlast_1         <= wlast_d;
      wvalid_1        <= wvalid_d;
      bready_1        <= bready_d;
      wr_frame_index  <= wr_idx_d;
      last_done_index <= last_done_d;
      done_valid      <= done_valid_d;
      frame_done      <= frame_done_d;
      sync_err        <= sync_err_d;
      busy            <= busy_d;
    end
  end

endmodule

// File: tb/tb_cam_ddr_frame_writer.sv
// Directed bench for cam_ddr_frame_writer with 2-beat bursts and 32-byte frames.
module tb_cam_ddr_frame_writer;

  logic        aclk = 1'b0;
  logic        rst, enable, cmos_init_done, frame_sync, rd_lock;
  logic [1:0]  rd_frame_index;
  logic [11:0] fifo_data_count;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic [31:0] awaddr_1;
  logic [7:0]  awlen_1;
  logic        awvalid_1, awready_1;
  logic [63:0] wdata_1;
  logic        wlast_1, wvalid_1, wready_1, bvalid_1, bready_1;
  logic [1:0]  wr_frame_index, last_done_index;
  logic        done_valid, frame_done, sync_err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_ptr = 0;
  int rd_ptr = 0;
  int exp_byte = 0;

  always #5 aclk = ~aclk;

  cam_ddr_frame_writer #(.BURST_BEATS(2), .FRAME_BYTES(32)) dut (
    .aclk(aclk), .rst(rst), .enable(enable), .cmos_init_done(cmos_init_done),
    .frame_sync(frame_sync), .rd_lock(rd_lock), .rd_frame_index(rd_frame_index),
    .fifo_data_count(fifo_data_count), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .awaddr_1(awaddr_1), .awlen_1(awlen_1), .awvalid_1(awvalid_1), .awready_1(awready_1),
    .wdata_1(wdata_1), .wlast_1(wlast_1), .wvalid_1(wvalid_1), .wready_1(wready_1),
    .bvalid_1(bvalid_1), .bready_1(bready_1), .wr_frame_index(wr_frame_index),
    .last_done_index(last_done_index), .done_valid(done_valid), .frame_done(frame_done),
    .sync_err(sync_err), .busy(busy)
  );

  // FIFO model: the byte at sequence position n holds value n mod 256
  assign fifo_data_count = 12'(wr_ptr - rd_ptr);
  always @(posedge aclk) begin
    if (fifo_rd_en) begin
      fifo_data <= 8'(rd_ptr);
      rd_ptr    <= rd_ptr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input int b);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(b + k);
    return v;
  endfunction

  task automatic sync_pulse();
    frame_sync = 1'b1;
    @(negedge aclk);
    frame_sync = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"},   64'(fifo_rd_en), 64'd0);
    chk({tag, "_awaddr"},  64'(awaddr_1), 64'd0);
    chk({tag, "_awvalid"}, 64'(awvalid_1), 64'd0);
    chk({tag, "_wdata"},   wdata_1, 64'd0);
    chk({tag, "_wflags"},  64'({wlast_1, wvalid_1, bready_1}), 64'd0);
    chk({tag, "_idx"},     64'({wr_frame_index, last_done_index}), 64'd0);
    chk({tag, "_status"},  64'({done_valid, frame_done, sync_err, busy}), 64'd0);
  endtask

  // One 2-beat burst against the slave model, with optional stalls and sync injection
  task automatic burst(input logic [31:0] exp_addr, input int aw_stall, input int w_stall,
                       input bit sync_in_aw, input bit sync_with_b);
    int rd0;
    logic [63:0] d;
    for (int t = 0; t < 100 && !awvalid_1; t++) @(negedge aclk);
    chk("awvalid", 64'(awvalid_1), 64'd1);
    chk("awaddr", 64'(awaddr_1), 64'(exp_addr));
    rd0 = rd_ptr;
    if (sync_in_aw) sync_pulse();
    if (aw_stall > 0) begin
      repeat (aw_stall) @(negedge aclk);
      chk("aw_stall_addr", 64'(awaddr_1), 64'(exp_addr));
      chk("aw_stall_hold", 64'({awvalid_1, fifo_rd_en}), 64'd2);
    end
    awready_1 = 1'b1;
    @(negedge aclk);
    awready_1 = 1'b0;
    chk("aw_drop", 64'(awvalid_1), 64'd0);
    for (int beat = 0; beat < 2; beat++) begin
      for (int t = 0; t < 100 && !wvalid_1; t++) @(negedge aclk);
      d = beat_val(exp_byte);
      chk("wdata", wdata_1, d);
      chk("wlast", 64'({wvalid_1, wlast_1}), (beat == 1) ? 64'd3 : 64'd2);
      if (beat == 0 && w_stall > 0) begin
        repeat (w_stall) @(negedge aclk);
        chk("w_stall_data", wdata_1, d);
        chk("w_stall_hold", 64'({wvalid_1, fifo_rd_en}), 64'd2);
      end
      wready_1 = 1'b1;
      @(negedge aclk);
      wready_1 = 1'b0;
      exp_byte += 8;
    end
    chk("pops", 64'(rd_ptr - rd0), 64'd16);
    for (int t = 0; t < 100 && !bready_1; t++) @(negedge aclk);
    chk("bready", 64'(bready_1), 64'd1);
    if (sync_with_b) frame_sync = 1'b1;
    bvalid_1 = 1'b1;
    @(negedge aclk);
    bvalid_1   = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic full_frame(input logic [31:0] base, input logic [1:0] done_idx,
                            input logic [1:0] next_idx);
    wr_ptr += 32;
    sync_pulse();
    burst(base, 0, 0, 1'b0, 1'b0);
    burst(base + 32'h10, 0, 0, 1'b0, 1'b0);
    chk("frame_done", 64'({frame_done, done_valid, busy}), 64'd6);
    chk("last_done_index", 64'(last_done_index), 64'(done_idx));
    chk("wr_frame_index", 64'(wr_frame_index), 64'(next_idx));
    @(negedge aclk);
    chk("frame_done_pulse", 64'(frame_done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cmos_init_done = 1'b0; frame_sync = 1'b0;
    rd_lock = 1'b0; rd_frame_index = 2'd0;
    awready_1 = 1'b0; wready_1 = 1'b0; bvalid_1 = 1'b0;
    repeat (3) @(negedge aclk);
    chk_zero("reset");
    chk("awlen", 64'(awlen_1), 64'd1);
    rst = 1'b0;

    // Frame into buffer 0 with AW and W stalls
    enable = 1'b1; cmos_init_done = 1'b1;
    wr_ptr += 32;
    @(negedge aclk);
    chk("wait_sync_busy", 64'(busy), 64'd0);
    sync_pulse();
    chk("wait_data_busy", 64'(busy), 64'd1);
    burst(32'h0, 5, 5, 1'b0, 1'b0);
    chk("first_beat_ref", 64'(exp_byte), 64'd16);
    burst(32'h10, 0, 0, 1'b0, 1'b0);
    chk("f0_done", 64'({frame_done, done_valid, busy}), 64'd6);
    chk("f0_last_done", 64'(last_done_index), 64'd0);
    chk("f0_next_idx", 64'(wr_frame_index), 64'd1);
    @(negedge aclk);
    chk("f0_done_pulse", 64'(frame_done), 64'd0);

    // Ring rotation without a lock
    full_frame(32'h0008_0000, 2'd1, 2'd2);
    full_frame(32'h0010_0000, 2'd2, 2'd0);

    // Reader holds buffer 1: completion of buffer 0 skips to 2
    rd_lock = 1'b1; rd_frame_index = 2'd1;
    full_frame(32'h0000_0000, 2'd0, 2'd2);

    // Sync during the second burst truncates the frame
    wr_ptr += 32;
    sync_pulse();
    burst(32'h0010_0000, 0, 0, 1'b0, 1'b0);
    burst(32'h0010_0010, 0, 0, 1'b1, 1'b0);
    chk("trunc_no_done", 64'({frame_done, sync_err, busy}), 64'd3);
    chk("trunc_idx", 64'({wr_frame_index, last_done_index}), 64'b1000);

    // Restarted frame; its final response coincides with a new sync
    wr_ptr += 32;
    burst(32'h0010_0000, 0, 0, 1'b0, 1'b0);
    burst(32'h0010_0010, 0, 0, 1'b0, 1'b1);
    chk("sim_done", 64'({frame_done, done_valid, sync_err, busy}), 64'd15);
    chk("sim_idx", 64'({wr_frame_index, last_done_index}), 64'b0010);

    // One byte short of a burst: no AW until the last byte arrives
    wr_ptr += 15;
    repeat (4) @(negedge aclk);
    chk("short_no_aw", 64'({awvalid_1, busy}), 64'd1);
    wr_ptr += 1;
    @(negedge aclk);
    chk("thresh_aw", 64'(awvalid_1), 64'd1);
    chk("thresh_addr", 64'(awaddr_1), 64'd0);

    // Reset while a write beat is pending
    awready_1 = 1'b1;
    @(negedge aclk);
    awready_1 = 1'b0;
    for (int t = 0; t < 100 && !wvalid_1; t++) @(negedge aclk);
    chk("pre_rst_wvalid", 64'(wvalid_1), 64'd1);
    rst = 1'b1;
    @(negedge aclk);
    chk_zero("mid_rst");
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
